// File: rtl/wave_meter.sv
// wave_meter: measures a unipolar sample stream (DDS output or ADC).
// One measurement has three phases:
//   AMP    - take WIN valid samples and track min/max -> vpp, mid
//   ARM    - wait for the first rising crossing through mid +/- HYST
//   PERIOD - count sys_clk cycles up to the next rising crossing
// Each result set is published together with a one-cycle meas_valid strobe.
//
// Optional feature: define WAVE_METER_AVG_EN to average the period over
// four successive crossing intervals (period = total >> 2).
//
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   start              begin one measurement (only honoured in IDLE)
//   cont               auto-restart after each result
//   sample_in/_valid   unsigned sample and its qualifier
//   busy               high whenever the FSM is not in IDLE
//   meas_valid         one-cycle strobe; results change on the same cycle
//   vpp, mid, period   max-min, (max+min)>>1, cycles between crossings
//   no_signal, timeout status flags, rewritten at every result
//   dbg_state          current FSM state (IDLE=0 AMP=1 ARM=2 PERIOD=3 DONE=4)
//
// Handshake: sample_in is consumed on every rising edge where sample_valid
// is 1; there is no back-pressure. meas_valid is a pulse, not a handshake.
module wave_meter #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 24,
  parameter int WIN    = 4096,
  parameter int HYST   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              cont,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              busy,
  output logic              meas_valid,
  output logic [DATA_W-1:0] vpp,
  output logic [DATA_W-1:0] mid,
  output logic [CNT_W-1:0]  period,
  output logic              no_signal,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AMP    = 3'd1,
    S_ARM    = 3'd2,
    S_PERIOD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0]   LAST_SMP = CW'(WIN - 1);
  localparam logic [DATA_W:0] HYST_X   = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0] NS_LIM   = (DATA_W + 1)'(2 * HYST);
  localparam logic [DATA_W:0] MAXV_X   = {1'b0, {DATA_W{1'b1}}};

  state_t              state_q;
  logic [DATA_W-1:0]   min_q, max_q;
  logic [CW-1:0]       count_q;
  logic                armed_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   amp_vpp_q, amp_mid_q;
  logic                busy_q, meas_valid_q, no_signal_q, timeout_q;
  logic [DATA_W-1:0]   vpp_q, mid_q;
  logic [CNT_W-1:0]    period_q;
`ifdef WAVE_METER_AVG_EN
  logic [1:0]          xcnt_q;
`endif

  // Window statistics including the sample arriving this cycle.
  logic [DATA_W-1:0]   min_d, max_d, vpp_d, mid_d;
  logic [DATA_W:0]     sum_d;
  assign min_d = (sample_in < min_q) ? sample_in : min_q;
  assign max_d = (sample_in > max_q) ? sample_in : max_q;
  assign vpp_d = max_d - min_d;
  assign sum_d = {1'b0, max_d} + {1'b0, min_d};
  assign mid_d = DATA_W'(sum_d >> 1);

  // Crossing thresholds around the latched midpoint, saturated at the rails.
  logic [DATA_W:0]     hi_sum;
  logic [DATA_W-1:0]   lo_thr, hi_thr;
  assign hi_sum = {1'b0, amp_mid_q} + HYST_X;
  assign hi_thr = (hi_sum > MAXV_X) ? {DATA_W{1'b1}} : hi_sum[DATA_W-1:0];
  assign lo_thr = ({1'b0, amp_mid_q} < HYST_X) ? '0
                : DATA_W'({1'b0, amp_mid_q} - HYST_X);

  logic below_lo, crossing;
  assign below_lo = sample_valid && (sample_in < lo_thr);
  assign crossing = sample_valid && armed_q && (sample_in >= hi_thr);

  // Which crossing ends the PERIOD phase, and how the count is scaled.
  logic             last_x;
  logic [CNT_W-1:0] per_res;
`ifdef WAVE_METER_AVG_EN
  assign last_x  = (xcnt_q == 2'd3);
  assign per_res = cnt_q >> 2;
`else
  assign last_x  = 1'b1;
  assign per_res = cnt_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      min_q        <= '1;
      max_q        <= '0;
      count_q      <= '0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      amp_vpp_q    <= '0;
      amp_mid_q    <= '0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b0;
      timeout_q    <= 1'b0;
      vpp_q        <= '0;
      mid_q        <= '0;
      period_q     <= '0;
`ifdef WAVE_METER_AVG_EN
      xcnt_q       <= '0;
`endif
    end else begin
      meas_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_AMP;
            busy_q  <= 1'b1;
            min_q   <= '1;
            max_q   <= '0;
            count_q <= '0;
          end
        end
        S_AMP: begin
          if (sample_valid) begin
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_q + CW'(1);
            if (count_q == LAST_SMP) begin
              amp_vpp_q <= vpp_d;
              amp_mid_q <= mid_d;
              armed_q   <= 1'b0;
              cnt_q     <= CNT_W'(1);
              if ({1'b0, vpp_d} <= NS_LIM) begin
                // Too small to find crossings reliably: report now.
                state_q      <= S_DONE;
                meas_valid_q <= 1'b1;
                vpp_q        <= vpp_d;
                mid_q        <= mid_d;
                period_q     <= '0;
                no_signal_q  <= 1'b1;
                timeout_q    <= 1'b0;
              end else begin
                state_q <= S_ARM;
              end
            end
          end
        end
        S_ARM, S_PERIOD: begin
          if (&cnt_q) begin
            // Saturation wins over a crossing on the same cycle.
            state_q      <= S_DONE;
            meas_valid_q <= 1'b1;
            vpp_q        <= amp_vpp_q;
            mid_q        <= amp_mid_q;
            period_q     <= '0;
            no_signal_q  <= 1'b0;
            timeout_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (below_lo) armed_q <= 1'b1;
            if (crossing) begin
              armed_q <= 1'b0;
              if (state_q == S_ARM) begin
                state_q <= S_PERIOD;
                cnt_q   <= CNT_W'(1);
`ifdef WAVE_METER_AVG_EN
                xcnt_q  <= '0;
`endif
              end else if (last_x) begin
                state_q      <= S_DONE;
                meas_valid_q <= 1'b1;
                vpp_q        <= amp_vpp_q;
                mid_q        <= amp_mid_q;
                period_q     <= per_res;
                no_signal_q  <= 1'b0;
                timeout_q    <= 1'b0;
              end else begin
`ifdef WAVE_METER_AVG_EN
                xcnt_q <= xcnt_q + 2'd1;
`endif
              end
            end
          end
        end
        S_DONE: begin
          if (cont) begin
            state_q <= S_AMP;
            min_q   <= '1;
            max_q   <= '0;
            count_q <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign meas_valid = meas_valid_q;
  assign vpp        = vpp_q;
  assign mid        = mid_q;
  assign period     = period_q;
  assign no_signal  = no_signal_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter. Two instances share the sample stream:
// dut (WIN=256, CNT_W=24) and dut_t (WIN=256, CNT_W=8) for timeout cases.
// Inputs are driven and outputs observed on the falling clock edge.
module tb_wave_meter;

  logic        sys_clk, sys_rst, start, start_t, cont;
  logic [11:0] sample_in;
  logic        sample_valid;

  logic        busy, meas_valid, no_signal, timeout;
  logic [11:0] vpp, mid;
  logic [23:0] period;
  logic [2:0]  dbg_state;

  logic        t_busy, t_meas_valid, t_no_signal, t_timeout;
  logic [11:0] t_vpp, t_mid;
  logic [7:0]  t_period;
  logic [2:0]  t_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus generator state
  int          mode;          // 0 dc, 1 square, 2 sawtooth
  int          phase;
  int          per;
  logic [11:0] sq_lo, sq_hi, dc_val;
  bit          valid_toggle;

  wave_meter #(.DATA_W(12), .CNT_W(24), .WIN(256), .HYST(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .cont(cont),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .busy(busy), .meas_valid(meas_valid), .vpp(vpp), .mid(mid),
    .period(period), .no_signal(no_signal), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  wave_meter #(.DATA_W(12), .CNT_W(8), .WIN(256), .HYST(16)) dut_t (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_t), .cont(1'b0),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .busy(t_busy), .meas_valid(t_meas_valid), .vpp(t_vpp), .mid(t_mid),
    .period(t_period), .no_signal(t_no_signal), .timeout(t_timeout),
    .dbg_state(t_dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One cycle: drive this cycle's inputs at the falling edge.
  task automatic tick(input bit s_main, input bit s_to);
    @(negedge sys_clk);
    start   = s_main;
    start_t = s_to;
    case (mode)
      0:       sample_in = dc_val;
      1:       sample_in = ((phase % per) < (per / 2)) ? sq_hi : sq_lo;
      default: sample_in = 12'((phase % 1000) * 4);
    endcase
    sample_valid = valid_toggle ? ~phase[0] : 1'b1;
    phase++;
  endtask

  task automatic wait_meas(input int budget, input bit which, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick(1'b0, 1'b0);
      n++;
      if (which ? t_meas_valid : meas_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    sys_rst = 1'b0;
    tick(1'b0, 1'b0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL rst_meas_valid: got %0b want 0", meas_valid); end
    n_checks++; if (vpp !== 12'd0 || mid !== 12'd0) begin n_fail++; $display("FAIL rst_vpp_mid: got %0d/%0d want 0/0", vpp, mid); end
    n_checks++; if (period !== 24'd0) begin n_fail++; $display("FAIL rst_period: got %0d want 0", period); end
    n_checks++; if (no_signal !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %0b/%0b want 0/0", no_signal, timeout); end
    n_checks++; if (dbg_state !== 3'd0 || t_busy !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %0d/%0b want 0/0", dbg_state, t_busy); end
  endtask

  task automatic test_square100();
    int n; bit ok;
    mode = 1; per = 100; sq_lo = 12'd0; sq_hi = 12'd4095; phase = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sq_busy: got %0b want 1", busy); end
    wait_meas(3000, 1'b0, n, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sq_meas: no meas_valid in 3000 cycles"); end
    n_checks++; if (vpp !== 12'd4095) begin n_fail++; $display("FAIL sq_vpp: got %0d want 4095", vpp); end
    n_checks++; if (mid !== 12'd2047) begin n_fail++; $display("FAIL sq_mid: got %0d want 2047", mid); end
    n_checks++; if (period !== 24'd100) begin n_fail++; $display("FAIL sq_period: got %0d want 100", period); end
    n_checks++; if (no_signal !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL sq_flags: got %0b/%0b want 0/0", no_signal, timeout); end
    tick(1'b0, 1'b0);
    n_checks++; if (meas_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sq_strobe_end: got mv=%0b busy=%0b want 0/0", meas_valid, busy); end
    n_checks++; if (period !== 24'd100) begin n_fail++; $display("FAIL sq_hold: got %0d want 100", period); end
  endtask

  task automatic test_dc();
    int n; bit ok;
    mode = 0; dc_val = 12'd2048; phase = 0;
    tick(1'b1, 1'b0);
    wait_meas(1000, 1'b0, n, ok);
    n_checks++; if (!ok || n != 257) begin n_fail++; $display("FAIL dc_latency: got %0d want 257", n); end
    n_checks++; if (vpp !== 12'd0 || mid !== 12'd2048) begin n_fail++; $display("FAIL dc_vpp_mid: got %0d/%0d want 0/2048", vpp, mid); end
    n_checks++; if (no_signal !== 1'b1 || timeout !== 1'b0 || period !== 24'd0) begin n_fail++; $display("FAIL dc_flags: got ns=%0b to=%0b per=%0d want 1/0/0", no_signal, timeout, period); end
  endtask

  task automatic test_ns_boundary();
    int n; bit ok;
    // vpp exactly 2*HYST: still no signal
    mode = 1; per = 100; sq_lo = 12'd0; sq_hi = 12'd32; phase = 0;
    tick(1'b1, 1'b0);
    wait_meas(1000, 1'b0, n, ok);
    n_checks++; if (!ok || no_signal !== 1'b1 || vpp !== 12'd32 || mid !== 12'd16) begin n_fail++; $display("FAIL ns_32: got ok=%0b ns=%0b vpp=%0d mid=%0d want 1/1/32/16", ok, no_signal, vpp, mid); end
    // one LSB more: measured, but lo saturates at 0 so it never arms
    sq_hi = 12'd33; phase = 0;
    tick(1'b0, 1'b1);
    wait_meas(1000, 1'b1, n, ok);
    n_checks++; if (!ok || n != 512) begin n_fail++; $display("FAIL ns_33_latency: got %0d want 512", n); end
    n_checks++; if (t_no_signal !== 1'b0 || t_timeout !== 1'b1 || t_period !== 8'd0) begin n_fail++; $display("FAIL ns_33_flags: got ns=%0b to=%0b per=%0d want 0/1/0", t_no_signal, t_timeout, t_period); end
    n_checks++; if (t_vpp !== 12'd33 || t_mid !== 12'd16) begin n_fail++; $display("FAIL ns_33_vpp_mid: got %0d/%0d want 33/16", t_vpp, t_mid); end
  endtask

  task automatic test_timeout_saw();
    int n; bit ok;
    mode = 2; phase = 0;
    tick(1'b0, 1'b1);
    wait_meas(2000, 1'b1, n, ok);
    n_checks++; if (!ok || n != 512) begin n_fail++; $display("FAIL saw_latency: got %0d want 512", n); end
    n_checks++; if (t_timeout !== 1'b1 || t_period !== 8'd0 || t_no_signal !== 1'b0) begin n_fail++; $display("FAIL saw_flags: got to=%0b per=%0d ns=%0b want 1/0/0", t_timeout, t_period, t_no_signal); end
    n_checks++; if (t_vpp !== 12'd1020 || t_mid !== 12'd514) begin n_fail++; $display("FAIL saw_vpp_mid: got %0d/%0d want 1020/514", t_vpp, t_mid); end
  endtask

  task automatic test_valid_toggle();
    int n; bit ok;
    mode = 1; per = 100; sq_lo = 12'd0; sq_hi = 12'd4095; phase = 0; valid_toggle = 1'b1;
    tick(1'b1, 1'b0);
    wait_meas(3000, 1'b0, n, ok);
    valid_toggle = 1'b0;
    n_checks++; if (!ok || period !== 24'd100 || vpp !== 12'd4095) begin n_fail++; $display("FAIL vt_period: got ok=%0b per=%0d vpp=%0d want 1/100/4095", ok, period, vpp); end
  endtask

  task automatic test_period101();
    int n; bit ok;
    mode = 1; per = 101; sq_lo = 12'd0; sq_hi = 12'd4095; phase = 0;
    tick(1'b1, 1'b0);
    wait_meas(3000, 1'b0, n, ok);
    n_checks++; if (!ok || period !== 24'd101) begin n_fail++; $display("FAIL p101: got ok=%0b per=%0d want 1/101", ok, period); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    mode = 1; per = 100; sq_lo = 12'd0; sq_hi = 12'd4095; phase = 0; cont = 1'b1;
    tick(1'b1, 1'b0);
    wait_meas(3000, 1'b0, n, ok);
    n_checks++; if (!ok || period !== 24'd100) begin n_fail++; $display("FAIL b2b_first: got ok=%0b per=%0d want 1/100", ok, period); end
    // switch the wave while in DONE; the stray start is ignored
    per = 60; phase = 0;
    tick(1'b1, 1'b0);
    repeat (50) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    wait_meas(3000, 1'b0, n, ok);
    n_checks++; if (!ok || period !== 24'd60 || vpp !== 12'd4095) begin n_fail++; $display("FAIL b2b_second: got ok=%0b per=%0d vpp=%0d want 1/60/4095", ok, period, vpp); end
    wait_meas(3000, 1'b0, n, ok);
    n_checks++; if (!ok || period !== 24'd60) begin n_fail++; $display("FAIL b2b_third: got ok=%0b per=%0d want 1/60", ok, period); end
    cont = 1'b0;
    tick(1'b0, 1'b0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n; int seen;
    mode = 1; per = 100; sq_lo = 12'd0; sq_hi = 12'd4095; phase = 0;
    tick(1'b1, 1'b0);
    n = 0;
    while (n < 3000 && dbg_state != 3'd3) begin tick(1'b0, 1'b0); n++; end
    n_checks++; if (dbg_state !== 3'd3) begin n_fail++; $display("FAIL rm_reach_period: got state %0d want 3", dbg_state); end
    sys_rst = 1'b1;
    tick(1'b0, 1'b0);
    sys_rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || meas_valid !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL rm_ctrl: got busy=%0b mv=%0b st=%0d want 0/0/0", busy, meas_valid, dbg_state); end
    n_checks++; if (vpp !== 12'd0 || mid !== 12'd0 || period !== 24'd0 || no_signal !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rm_results: got vpp=%0d mid=%0d per=%0d ns=%0b to=%0b want all 0", vpp, mid, period, no_signal, timeout); end
    seen = 0;
    repeat (600) begin tick(1'b0, 1'b0); if (meas_valid) seen++; end
    n_checks++; if (seen != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: got %0d strobes busy=%0b want 0/0", seen, busy); end
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; start_t = 1'b0; cont = 1'b0;
    sample_in = '0; sample_valid = 1'b0;
    mode = 0; phase = 0; per = 100; sq_lo = '0; sq_hi = '0; dc_val = '0;
    valid_toggle = 1'b0;
    test_reset();
    test_square100();
    test_dc();
    test_ns_boundary();
    test_timeout_saw();
    test_valid_toggle();
    test_period101();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
